sevseg_scan_ctrl: RTL and testbench

SEVSEG_SCAN_CTRL -- requirements
Module: sevseg_scan_ctrl

---
 rtl/sevseg_pkg.sv | 37 +++
 rtl/sevseg_decode.sv | 11 +
 rtl/sevseg_scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_sevseg_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Holds the glyph table, active-low "off" values and the output polarity helper.
package sevseg_pkg;

   localparam int MAX_DIGITS = 16;

   // Everything below is in active-low form; polarity is applied once at the outputs.
   localparam logic [6:0]            SEG_OFF = 7'b111_1111;
   localparam logic [MAX_DIGITS-1:0] DIG_OFF = {MAX_DIGITS{1'b1}};
   localparam logic                  DP_OFF  = 1'b1;

   // Segment order {a,b,c,d,e,f,g}, MSB = a.
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0000100,   // 9
      7'b0001000,   // A
      7'b1100000,   // b
      7'b0110001,   // C
      7'b1000010,   // d
      7'b0110000,   // E
      7'b0111000    // F
   };

   // XOR mask turning an active-low value into the pin polarity.
   function automatic logic [MAX_DIGITS-1:0] polarity_mask(input logic active_low);
      return active_low ? {MAX_DIGITS{1'b0}} : {MAX_DIGITS{1'b1}};
   endfunction

endpackage

// File: rtl/sevseg_decode.sv
// Hex nibble to seven-segment glyph, active-low form.
module sevseg_decode
   import sevseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph_n
);

   assign glyph_n = GLYPH_TABLE[nibble];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with per-frame input snapshot,
// blanking, leading-zero suppression and PWM brightness.
module sevseg_scan_ctrl
   import sevseg_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int DIM_BITS   = 3,
   parameter int ACTIVE_LOW = 1
)(
   input  logic                    clk_7seg,
   input  logic                    Rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    lz_suppress,
   input  logic [DIM_BITS-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIM_BITS-1:0]   SUB_MAX  = {DIM_BITS{1'b1}};
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [MAX_DIGITS-1:0] POL_MASK = polarity_mask(ACTIVE_LOW != 0);

   logic [DIM_BITS-1:0]     sub_cnt_q, sub_cnt_d;
   logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
   logic                    frame_done_q, frame_done_d;

   logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
   logic                    snap_lz_q, snap_lz_d;

   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;

   logic [NUM_DIGITS-1:0]   nib_zero;
   logic [NUM_DIGITS-1:0]   digit_dark;
   logic [3:0]              cur_nibble;
   logic [6:0]              cur_glyph_n;
   logic                    digit_lit;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [6:0]              seg_n;
   logic                    dp_n;

   // ---------------------------------------------------------------- scan counters
   always_comb begin
      sub_cnt_d = sub_cnt_q + 1'b1;
      dig_idx_d = dig_idx_q;
      if (sub_cnt_q == SUB_MAX) begin
         dig_idx_d = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
      end
      if (Rst) begin
         sub_cnt_d = '0;
         dig_idx_d = '0;
      end
      // Registered look-ahead: high exactly while the counters sit on the last slot.
      frame_done_d = !Rst && (dig_idx_d == IDX_LAST) && (sub_cnt_d == SUB_MAX);
   end

   // ---------------------------------------------------------------- frame snapshot
   always_comb begin
      snap_value_d = snap_value_q;
      snap_dp_d    = snap_dp_q;
      snap_blank_d = snap_blank_q;
      snap_lz_d    = snap_lz_q;
      if (frame_done_q) begin
         snap_value_d = value;
         snap_dp_d    = dp_in;
         snap_blank_d = blank_mask;
         snap_lz_d    = lz_suppress;
      end
      // Blank-all snapshot keeps the first frame after reset dark.
      if (Rst) begin
         snap_value_d = '0;
         snap_dp_d    = '0;
         snap_blank_d = '1;
         snap_lz_d    = 1'b0;
      end
   end

   // ---------------------------------------------------------------- per-digit darkness
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib_zero[gi] = (snap_value_q[4*gi +: 4] == 4'h0);
      end
   endgenerate

   // Walk from the most significant digit down, tracking "all zero from here up".
   always_comb begin
      logic tail_zero;
      tail_zero  = 1'b1;
      digit_dark = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         tail_zero     = tail_zero & nib_zero[i];
         digit_dark[i] = snap_blank_q[i] | (snap_lz_q & tail_zero & (i != 0));
      end
   end

   // ---------------------------------------------------------------- display drive
   assign cur_nibble = snap_value_q[{dig_idx_q, 2'b00} +: 4];

   sevseg_decode u_decode (
      .nibble  (cur_nibble),
      .glyph_n (cur_glyph_n)
   );

   assign digit_lit = !digit_dark[dig_idx_q] && (sub_cnt_q <= brightness);

   always_comb begin
      an_n  = DIG_OFF[NUM_DIGITS-1:0];
      seg_n = SEG_OFF;
      dp_n  = DP_OFF;
      if (digit_lit && !Rst) begin
         an_n[dig_idx_q] = 1'b0;
         seg_n           = cur_glyph_n;
         dp_n            = ~snap_dp_q[dig_idx_q];
      end
      an_d  = an_n ^ POL_MASK[NUM_DIGITS-1:0];
      seg_d = seg_n ^ POL_MASK[6:0];
      dp_d  = dp_n ^ POL_MASK[0];
   end

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clk_7seg) begin
      sub_cnt_q    <= sub_cnt_d;
      dig_idx_q    <= dig_idx_d;
      frame_done_q <= frame_done_d;
      snap_value_q <= snap_value_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      snap_lz_q    <= snap_lz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl (8 digits, 3-bit dimming, active-low)
// with a cycle model feeding a scoreboard of expected display outputs.
module tb_sevseg_scan_ctrl;

   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic        clk_7seg = 1'b0;
   logic        Rst;
   logic [31:0] value;
   logic [7:0]  dp_in;
   logic [7:0]  blank_mask;
   logic        lz_suppress;
   logic [2:0]  brightness;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   // Model state: position in frame since reset and the snapshot being shown.
   int          k;
   logic [31:0] m_value;
   logic [7:0]  m_dp;
   logic [7:0]  m_blank;
   logic        m_lz;
   exp_t        sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   sevseg_scan_ctrl #(
      .NUM_DIGITS (8),
      .DIM_BITS   (3),
      .ACTIVE_LOW (1)
   ) dut (
      .clk_7seg    (clk_7seg),
      .Rst         (Rst),
      .value       (value),
      .dp_in       (dp_in),
      .blank_mask  (blank_mask),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   always #5 clk_7seg = ~clk_7seg;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp_v, k);
      end
   endtask

   // One clock: push the expected output for the current slot, advance, compare.
   task automatic cycle();
      exp_t e;
      int   dig;
      int   sub;
      logic dark;
      logic lit;
      dig  = (k / 8) % 8;
      sub  = k % 8;
      dark = m_blank[dig] || (m_lz && dig > 0 && (m_value >> (4 * dig)) == 32'h0);
      lit  = !Rst && !dark && (sub <= int'(brightness));
      e.an  = lit ? ~(8'h01 << dig) : 8'hFF;
      e.seg = lit ? GLYPH[m_value[4*dig +: 4]] : 7'h7F;
      e.dp  = lit ? ~m_dp[dig] : 1'b1;
      sb.push_back(e);
      if (!Rst && (k % 64 == 63)) begin
         m_value = value;
         m_dp    = dp_in;
         m_blank = blank_mask;
         m_lz    = lz_suppress;
      end
      @(posedge clk_7seg);
      #1;
      if (Rst) begin
         k       = 0;
         m_value = 32'h0;
         m_dp    = 8'h00;
         m_blank = 8'hFF;
         m_lz    = 1'b0;
      end else begin
         k++;
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 16'(sb.size()), 16'd1);
      end else begin
         e = sb.pop_front();
         chk("an", 16'(an), 16'(e.an));
         chk("seg", 16'(seg), 16'(e.seg));
         chk("dp", 16'(dp), 16'(e.dp));
         chk("frame_done", 16'(frame_done), 16'(k % 64 == 63));
      end
   endtask

   task automatic run_to(input int target);
      while (k < target) cycle();
   endtask

   initial begin
      k           = 0;
      m_value     = 32'h0;
      m_dp        = 8'h00;
      m_blank     = 8'hFF;
      m_lz        = 1'b0;
      Rst         = 1'b1;
      value       = 32'h1234ABCD;
      dp_in       = 8'h00;
      blank_mask  = 8'h00;
      lz_suppress = 1'b0;
      brightness  = 3'd7;

      // Reset state
      repeat (3) cycle();
      chk("rst_an", 16'(an), 16'h00FF);
      chk("rst_seg", 16'(seg), 16'h007F);
      chk("rst_fd", 16'(frame_done), 16'h0);

      // First frame dark, then 1234ABCD from digit 0 upward
      Rst = 1'b0;
      run_to(30);
      chk("f0_dark_an", 16'(an), 16'h00FF);
      run_to(63);
      chk("f0_fd", 16'(frame_done), 16'h1);
      run_to(65);
      chk("d0_an", 16'(an), 16'h00FE);
      chk("d0_seg", 16'(seg), 16'(7'b1000010));
      run_to(72);
      chk("d0_end_an", 16'(an), 16'h00FE);
      run_to(73);
      chk("d1_an", 16'(an), 16'h00FD);
      chk("d1_seg", 16'(seg), 16'(7'b0110001));

      // Live brightness 2, next frame leading-zero suppression of 00000105
      brightness  = 3'd2;
      lz_suppress = 1'b1;
      value       = 32'h00000105;
      run_to(131);
      chk("lz_d0_an", 16'(an), 16'h00FE);
      chk("lz_d0_seg", 16'(seg), 16'(7'b0100100));
      run_to(132);
      chk("dim_off_an", 16'(an), 16'h00FF);
      run_to(137);
      chk("lz_d1_an", 16'(an), 16'h00FD);
      chk("lz_d1_seg", 16'(seg), 16'(7'b0000001));
      run_to(145);
      chk("lz_d2_an", 16'(an), 16'h00FB);
      chk("lz_d2_seg", 16'(seg), 16'(7'b1001111));
      run_to(153);
      chk("lz_d3_an", 16'(an), 16'h00FF);
      run_to(191);
      chk("f2_fd", 16'(frame_done), 16'h1);

      // Inputs changed in the frame_done cycle itself are captured
      value       = 32'h11111111;
      lz_suppress = 1'b0;
      brightness  = 3'd7;
      run_to(212);
      value = 32'h22222222;
      run_to(250);
      chk("hold_seg", 16'(seg), 16'(7'b1001111));
      run_to(256);
      chk("hold_last_seg", 16'(seg), 16'(7'b1001111));
      run_to(257);
      chk("new_seg", 16'(seg), 16'(7'b0010010));

      // Decimal point on digit 0, digit 7 blanked
      dp_in      = 8'h01;
      blank_mask = 8'h80;
      run_to(321);
      chk("dp_d0", 16'(dp), 16'h0);
      chk("dp_d0_an", 16'(an), 16'h00FE);
      run_to(329);
      chk("dp_d1", 16'(dp), 16'h1);
      run_to(377);
      chk("blank_d7_an", 16'(an), 16'h00FF);

      // Reset mid-frame at frame cycle 30
      run_to(414);
      Rst = 1'b1;
      cycle();
      chk("abort_an", 16'(an), 16'h00FF);
      chk("abort_fd", 16'(frame_done), 16'h0);
      Rst = 1'b0;
      run_to(40);
      chk("post_rst_dark", 16'(an), 16'h00FF);
      run_to(62);
      chk("post_rst_fd0", 16'(frame_done), 16'h0);
      run_to(63);
      chk("post_rst_fd1", 16'(frame_done), 16'h1);
      run_to(70);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
